// File: rtl/pc_sequencer.sv
// Program-counter stage of the single-cycle MIPS core: holds the PC and selects the next PC.
// It also handles stall, halt, misaligned-target traps (with EPC capture) and counts retired instructions.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt,
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] pc_out,
    output logic        pc_valid,
    output logic        halted,
    output logic        exc_flag,
    output logic [31:0] epc,
    output logic [31:0] retire_count
);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] retire_q, retire_d;
    logic        exc_q, exc_d;
    logic [31:0] cand;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VECTOR;
            epc_q    <= 32'd0;
            retire_q <= 32'd0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            retire_q <= retire_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        retire_d = retire_q;
        exc_d    = 1'b0;
        cand     = pc_plus4;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                // Stall outranks halt, so a stalled halt is not taken.
                if (stall) begin
                    state_d = RUN;
                end else if (halt) begin
                    state_d  = HALTED;
                    retire_d = retire_q + 32'd1;
                end else begin
                    if (jump_reg)          cand = reg_target;
                    else if (jump)         cand = {pc_plus4[31:28], jump_index, 2'b00};
                    else if (branch_taken) cand = branch_target;
                    else                   cand = pc_plus4;
                    retire_d = retire_q + 32'd1;
                    if (cand[1:0] != 2'b00) begin
                        pc_d  = EXC_VECTOR;
                        epc_d = pc_q;
                        exc_d = 1'b1;
                    end else begin
                        pc_d = cand;
                    end
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_out       = pc_q;
        pc_valid     = (state_q == RUN);
        halted       = (state_q == HALTED);
        exc_flag     = exc_q;
        epc          = epc_q;
        retire_count = retire_q;
    end

endmodule
